// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: at the start of horizontal blanking it walks the
// sprite attribute table and issues one fetch request per sprite on the next line.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 20,
  parameter int SPRITE_SIZE  = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int HACTIVE      = 640,
  parameter int VACTIVE      = 480,
  parameter int VTOTAL       = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  VGA_HCOUNT,
  input  logic [9:0]  VGA_VCOUNT,
  output logic [4:0]  attr_addr,
  input  logic [23:0] attr_data,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [4:0]  req_id,
  output logic [9:0]  req_x,
  output logic [5:0]  req_row,
  output logic        busy,
  output logic        line_done,
  output logic        overflow,
  output logic        late
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_ISSUE,
    S_DONE
  } state_e;

  localparam logic [9:0]  HBLANK_START = 10'(HACTIVE);
  localparam logic [9:0]  LAST_LINE    = 10'(VTOTAL - 1);
  localparam logic [10:0] VISIBLE      = 11'(VACTIVE);
  localparam logic [10:0] SIZE11       = 11'(SPRITE_SIZE);
  localparam logic [4:0]  LAST_IDX     = 5'(NUM_SPRITES - 1);
  localparam logic [3:0]  MAX_CNT      = 4'(MAX_PER_LINE);

  state_e      state_q, state_d;
  logic [4:0]  index_q, index_d;
  logic [3:0]  count_q, count_d;
  logic [9:0]  target_q, target_d;
  logic        overflow_q, overflow_d;
  logic        late_q, late_d;
  logic [4:0]  req_id_q, req_id_d;
  logic [9:0]  req_x_q, req_x_d;
  logic [5:0]  req_row_q, req_row_d;

  logic [10:0] next_line;
  logic        trigger;
  logic [4:0]  attr_id;
  logic [8:0]  attr_y;
  logic [9:0]  attr_x;
  logic [10:0] target11;
  logic [10:0] y11;
  logic        hit;
  logic        last_entry;

  // Computed at 11 bits so a stray vcount of 1023 cannot wrap into a visible line.
  assign next_line = (VGA_VCOUNT == LAST_LINE) ? 11'd0 : {1'b0, VGA_VCOUNT} + 11'd1;
  assign trigger   = (VGA_HCOUNT == HBLANK_START) && (next_line < VISIBLE);

  assign attr_id    = attr_data[23:19];
  assign attr_y     = attr_data[18:10];
  assign attr_x     = attr_data[9:0];
  assign target11   = {1'b0, target_q};
  assign y11        = {2'b00, attr_y};
  assign hit        = (attr_id != 5'd0) && (target11 >= y11) && (target11 < y11 + SIZE11);
  assign last_entry = (index_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      count_q    <= '0;
      target_q   <= '0;
      overflow_q <= 1'b0;
      late_q     <= 1'b0;
      req_id_q   <= '0;
      req_x_q    <= '0;
      req_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      count_q    <= count_d;
      target_q   <= target_d;
      overflow_q <= overflow_d;
      late_q     <= late_d;
      req_id_q   <= req_id_d;
      req_x_q    <= req_x_d;
      req_row_q  <= req_row_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    count_d    = count_q;
    target_d   = target_q;
    overflow_d = overflow_q;
    late_d     = 1'b0;
    req_id_d   = req_id_q;
    req_x_d    = req_x_q;
    req_row_d  = req_row_q;

    // A trigger always wins: it aborts any scan in flight and restarts at entry 0.
    if (trigger) begin
      state_d    = S_READ;
      index_d    = '0;
      count_d    = '0;
      target_d   = next_line[9:0];
      overflow_d = 1'b0;
      late_d     = (state_q != S_IDLE);
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_READ: state_d = S_EVAL;
        S_EVAL: begin
          if (hit) begin
            if (count_q < MAX_CNT) begin
              state_d   = S_ISSUE;
              req_id_d  = attr_id;
              req_x_d   = attr_x;
              req_row_d = target_q[5:0] - attr_y[5:0];
            end else begin
              overflow_d = 1'b1;
              state_d    = S_DONE;
            end
          end else if (last_entry) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 5'd1;
            state_d = S_READ;
          end
        end
        S_ISSUE: begin
          if (req_ready) begin
            count_d = count_q + 4'd1;
            if (last_entry) begin
              state_d = S_DONE;
            end else begin
              index_d = index_q + 5'd1;
              state_d = S_READ;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    line_done = (state_q == S_DONE);
    req_valid = (state_q == S_ISSUE);
  end

  assign attr_addr = index_q;
  assign req_id    = req_id_q;
  assign req_x     = req_x_q;
  assign req_row   = req_row_q;
  assign overflow  = overflow_q;
  assign late      = late_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: attribute RAM model plus a reference model that
// derives the expected request list, overflow and scan length from the sprite table.
module tb_sprite_line_scheduler;

  localparam int NUM  = 20;
  localparam int SIZE = 64;
  localparam int MAXL = 8;
  localparam int VTOT = 525;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  VGA_HCOUNT = 10'd0;
  logic [9:0]  VGA_VCOUNT = 10'd0;
  logic [4:0]  attr_addr;
  logic [23:0] attr_data = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [4:0]  req_id;
  logic [9:0]  req_x;
  logic [5:0]  req_row;
  logic        busy;
  logic        line_done;
  logic        overflow;
  logic        late;

  logic [23:0] mem [32];
  int vectors = 0;
  int errors  = 0;

  sprite_line_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .VGA_HCOUNT (VGA_HCOUNT),
    .VGA_VCOUNT (VGA_VCOUNT),
    .attr_addr  (attr_addr),
    .attr_data  (attr_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_id     (req_id),
    .req_x      (req_x),
    .req_row    (req_row),
    .busy       (busy),
    .line_done  (line_done),
    .overflow   (overflow),
    .late       (late)
  );

  always #5 clk = ~clk;

  // Synchronous attribute RAM: data appears one cycle after the address.
  always @(posedge clk) attr_data <= mem[attr_addr];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] entry(input int id, input int y, input int x);
    return {5'(id), 9'(y), 10'(x)};
  endfunction

  function automatic bit model_hit(input logic [23:0] e, input int t);
    int y;
    y = int'(e[18:10]);
    return (e[23:19] != 5'd0) && (t >= y) && (t < y + SIZE);
  endfunction

  task automatic clear_table();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic fire_trigger(input logic [9:0] vc, input logic exp_late, input string tag);
    @(negedge clk);
    req_ready  = 1'b0;
    VGA_HCOUNT = 10'd640;
    VGA_VCOUNT = vc;
    @(negedge clk);
    VGA_HCOUNT = 10'd641;
    vectors++;
    if (busy !== 1'b1 || late !== exp_late || attr_addr !== 5'd0 || overflow !== 1'b0 ||
        req_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b late=%b addr=%0d ovf=%b valid=%b, expected busy=1 late=%b addr=0 ovf=0 valid=0",
               tag, busy, late, attr_addr, overflow, req_valid, exp_late);
    end
  endtask

  // Observes one scan from the first cycle after its trigger until line_done.
  task automatic monitor_scan(input logic [9:0] vc, input int ready_pct, input int stall_first,
                              input string tag);
    int t, n, got, vcycles, stall_k, exp_scanned, acc_idx, eidx;
    bit exp_ovf, done, hold, after_acc, late_seen;
    int exp_list[$];
    logic [20:0] held;
    logic [23:0] e;
    t = (int'(vc) == VTOT - 1) ? 0 : int'(vc) + 1;
    exp_ovf = 1'b0;
    exp_scanned = NUM;
    for (int i = 0; i < NUM; i++) begin
      if (model_hit(mem[i], t)) begin
        if (exp_list.size() == MAXL) begin
          exp_ovf = 1'b1;
          exp_scanned = i + 1;
          break;
        end
        exp_list.push_back(i);
      end
    end
    n = 1; got = 0; vcycles = 0; stall_k = 0; acc_idx = 0;
    done = 0; hold = 0; after_acc = 0; late_seen = 0;
    held = '0;
    while (!done && n < 600) begin
      if (n >= 2 && late === 1'b1) late_seen = 1'b1;
      if (after_acc) begin
        vectors++;
        if (req_valid !== 1'b0 || attr_addr !== 5'(acc_idx == NUM - 1 ? acc_idx : acc_idx + 1)) begin
          errors++;
          $display("FAIL %s post_accept: valid=%b addr=%0d, expected valid=0 addr=%0d", tag,
                   req_valid, attr_addr, acc_idx == NUM - 1 ? acc_idx : acc_idx + 1);
        end
        after_acc = 0;
      end
      if (hold) begin
        vectors++;
        if (req_valid !== 1'b1 || {req_id, req_x, req_row} !== held) begin
          errors++;
          $display("FAIL %s stall_stable: valid=%b fields=%h, expected valid=1 fields=%h", tag,
                   req_valid, {req_id, req_x, req_row}, held);
        end
        hold = 0;
      end
      if (req_valid === 1'b1) begin
        vcycles++;
        if (stall_k < stall_first) req_ready = 1'b0;
        else req_ready = ($urandom_range(99) < ready_pct);
        if (req_ready) begin
          vectors++;
          if (got >= exp_list.size()) begin
            errors++;
            $display("FAIL %s extra_request: id=%0d addr=%0d, expected only %0d requests", tag,
                     req_id, attr_addr, exp_list.size());
            acc_idx = int'(attr_addr);
          end else begin
            eidx = exp_list[got];
            e = mem[eidx];
            acc_idx = eidx;
            if (attr_addr !== 5'(eidx) || req_id !== e[23:19] || req_x !== e[9:0] ||
                req_row !== 6'(t - int'(e[18:10]))) begin
              errors++;
              $display("FAIL %s request%0d: idx=%0d id=%0d x=%0d row=%0d, expected idx=%0d id=%0d x=%0d row=%0d",
                       tag, got, attr_addr, req_id, req_x, req_row, eidx, e[23:19], e[9:0],
                       6'(t - int'(e[18:10])));
            end
          end
          got++;
          after_acc = 1;
          stall_k = 0;
        end else begin
          stall_k++;
          hold = 1;
          held = {req_id, req_x, req_row};
        end
      end else begin
        req_ready = ($urandom_range(99) < ready_pct);
      end
      if (line_done === 1'b1) begin
        done = 1;
        vectors++;
        if (n != 1 + 2 * exp_scanned + vcycles) begin
          errors++;
          $display("FAIL %s done_latency: line_done after %0d cycles, expected %0d", tag, n,
                   1 + 2 * exp_scanned + vcycles);
        end
        vectors++;
        if (got != exp_list.size() || overflow !== exp_ovf || late_seen) begin
          errors++;
          $display("FAIL %s result: requests=%0d ovf=%b late_seen=%b, expected requests=%0d ovf=%b late_seen=0",
                   tag, got, overflow, late_seen, exp_list.size(), exp_ovf);
        end
      end
      @(negedge clk);
      n++;
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL %s timeout: no line_done in %0d cycles, expected one", tag, n);
    end else begin
      vectors++;
      if (busy !== 1'b0 || line_done !== 1'b0 || overflow !== exp_ovf) begin
        errors++;
        $display("FAIL %s idle_after: busy=%b done=%b ovf=%b, expected busy=0 done=0 ovf=%b",
                 tag, busy, line_done, overflow, exp_ovf);
      end
    end
    req_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({attr_addr, req_valid, req_id, req_x, req_row, busy, line_done, overflow, late} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {attr_addr, req_valid, req_id, req_x, req_row, busy, line_done, overflow, late});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    VGA_HCOUNT = 10'd641;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || req_valid !== 1'b0 || attr_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b valid=%b addr=%0d, expected 0 0 0", busy, req_valid, attr_addr);
    end
  endtask

  task automatic test_empty_table();
    clear_table();
    fire_trigger(10'd10, 1'b0, "empty");
    monitor_scan(10'd10, 100, 0, "empty");
  endtask

  task automatic test_single_sprite();
    clear_table();
    mem[3] = entry(1, 11, 100);
    fire_trigger(10'd10, 1'b0, "single_row0");
    monitor_scan(10'd10, 100, 0, "single_row0");
    fire_trigger(10'd73, 1'b0, "single_row63");
    monitor_scan(10'd73, 100, 0, "single_row63");
    fire_trigger(10'd74, 1'b0, "single_miss");
    monitor_scan(10'd74, 100, 0, "single_miss");
  endtask

  task automatic test_overflow();
    clear_table();
    for (int i = 0; i < 10; i++) mem[i] = entry(i + 1, 20 - 2 * i, 50 * i);
    fire_trigger(10'd19, 1'b0, "overflow");
    monitor_scan(10'd19, 100, 0, "overflow");
    clear_table();
    fire_trigger(10'd19, 1'b0, "overflow_clear");
    monitor_scan(10'd19, 100, 0, "overflow_clear");
  endtask

  task automatic test_backpressure();
    clear_table();
    mem[4] = entry(6, 100, 321);
    mem[9] = entry(2, 90, 7);
    fire_trigger(10'd120, 1'b0, "backpressure");
    monitor_scan(10'd120, 100, 5, "backpressure");
  endtask

  task automatic test_wrap();
    clear_table();
    mem[5] = entry(7, 0, 300);
    fire_trigger(10'd524, 1'b0, "wrap");
    monitor_scan(10'd524, 100, 0, "wrap");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      VGA_HCOUNT = 10'd640;
      VGA_VCOUNT = (k == 0) ? 10'd479 : 10'd500;
      @(negedge clk);
      VGA_HCOUNT = 10'd641;
      repeat (3) begin
        vectors++;
        if (busy !== 1'b0 || line_done !== 1'b0) begin
          errors++;
          $display("FAIL no_trigger vcount=%0d: busy=%b done=%b, expected 0 0", VGA_VCOUNT, busy, line_done);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_late_and_reset();
    int k;
    clear_table();
    mem[2] = entry(4, 5, 200);
    mem[6] = entry(9, 30, 50);
    fire_trigger(10'd10, 1'b0, "late_first");
    k = 0;
    while (req_valid !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (req_valid !== 1'b1 || req_id !== 5'd4) begin
      errors++;
      $display("FAIL late_pending: valid=%b id=%0d, expected valid=1 id=4", req_valid, req_id);
    end
    VGA_HCOUNT = 10'd640;
    VGA_VCOUNT = 10'd30;
    @(negedge clk);
    VGA_HCOUNT = 10'd641;
    vectors++;
    if (late !== 1'b1 || req_valid !== 1'b0 || attr_addr !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL late_pulse: late=%b valid=%b addr=%0d busy=%b, expected 1 0 0 1",
               late, req_valid, attr_addr, busy);
    end
    monitor_scan(10'd30, 100, 0, "late_rescan");

    fire_trigger(10'd10, 1'b0, "reset_scan");
    k = 0;
    while (req_valid !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({attr_addr, req_valid, req_id, req_x, req_row, busy, line_done, overflow, late} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h, expected 0",
               {attr_addr, req_valid, req_id, req_x, req_row, busy, line_done, overflow, late});
    end
    @(negedge clk);
    reset = 1'b0;
    req_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (req_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_reset: valid=%b busy=%b, expected 0 0", req_valid, busy);
      end
    end
    req_ready = 1'b0;
  endtask

  task automatic test_random();
    int t, spread, yv, pct;
    logic [9:0] vc;
    for (int it = 0; it < 25; it++) begin
      vc = ($urandom_range(3) == 0) ? 10'd524 : 10'($urandom_range(478));
      t = (vc == 10'd524) ? 0 : int'(vc) + 1;
      spread = ($urandom_range(1) == 0) ? 90 : 300;
      for (int i = 0; i < NUM; i++) begin
        yv = t - 70 + int'($urandom_range(spread));
        if (yv < 0) yv = 0;
        if (yv > 511) yv = 511;
        mem[i] = {($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31, 1)), 9'(yv),
                  10'($urandom_range(1023))};
      end
      pct = int'($urandom_range(100, 25));
      fire_trigger(vc, 1'b0, "random");
      monitor_scan(vc, pct, 0, "random");
    end
  endtask

  initial begin
    clear_table();
    test_reset();
    test_empty_table();
    test_single_sprite();
    test_overflow();
    test_backpressure();
    test_wrap();
    test_late_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
